calc_port_sequencer: RTL and testbench

Hardware request sequencer on the upstream side of the calculator DUT wrapper. It accepts complete operations (opcode plus two operands) over a valid/ready interface and buffers them in a small FIFO. It drives them onto one calculator port using the two-cycle command/operand protocol, then waits for the port response. Each result is returned, in order, on a downstream valid/ready response interface.

---
 rtl/calc_port_sequencer.sv | 167 ++++++++++++++++
 tb/tb_calc_port_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_port_sequencer.sv
// Request sequencer in front of one calculator port: buffers whole operations in a FIFO,
// issues them with the two-cycle command/operand protocol and returns results in order.
module calc_port_sequencer #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_op1,
  input  logic [DATA_W-1:0] cmd_op2,
  output logic [3:0]        req_cmd_in,
  output logic [DATA_W-1:0] req_data_in,
  input  logic [1:0]        out_resp,
  input  logic [DATA_W-1:0] out_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_code,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        rsp_op,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND1, SEND2, WAIT, HOLD} state_t;

  state_t              state_q;
  logic [3:0]          fifo_op_q [DEPTH];
  logic [DATA_W-1:0]   fifo_a_q  [DEPTH];
  logic [DATA_W-1:0]   fifo_b_q  [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                cmd_ready_q;
  logic [TW-1:0]       cnt_q;
  logic [3:0]          op_q;
  logic [DATA_W-1:0]   op2_q;
  logic [3:0]          req_cmd_q;
  logic [DATA_W-1:0]   req_data_q;
  logic                rsp_valid_q;
  logic [1:0]          rsp_code_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [3:0]          rsp_op_q;

  logic                push, pop, head_ok;
  logic [3:0]          head_op;
  logic [DATA_W-1:0]   head_a, head_b;

  // cmd_ready is registered and already low when full, so a push is never granted into a full FIFO.
  assign push    = cmd_valid && cmd_ready_q;
  assign pop     = (state_q == IDLE) && (count_q != '0);
  assign head_op = fifo_op_q[rd_ptr_q];
  assign head_a  = fifo_a_q[rd_ptr_q];
  assign head_b  = fifo_b_q[rd_ptr_q];
  assign head_ok = (head_op == 4'd1) || (head_op == 4'd2) || (head_op == 4'd5) || (head_op == 4'd6);

  always_comb begin
    // NOTE: default assignment first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // NOTE: storage array has no reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op_q[wr_ptr_q] <= cmd_op;
      fifo_a_q[wr_ptr_q]  <= cmd_op1;
      fifo_b_q[wr_ptr_q]  <= cmd_op2;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      cnt_q       <= '0;
      op_q        <= 4'd0;
      op2_q       <= '0;
      req_cmd_q   <= 4'd0;
      req_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= 2'd0;
      rsp_data_q  <= '0;
      rsp_op_q    <= 4'd0;
    end else begin
      count_q     <= count_d;
      cmd_ready_q <= (count_d != CW'(DEPTH));
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (pop) begin
            op_q  <= head_op;
            op2_q <= head_b;
            if (head_ok) begin
              state_q    <= SEND1;
              req_cmd_q  <= head_op;
              req_data_q <= head_a;
            end else begin
              // Unsupported opcode never reaches the port; report it as an error straight away.
              state_q     <= HOLD;
              rsp_valid_q <= 1'b1;
              rsp_code_q  <= 2'd2;
              rsp_data_q  <= '0;
              rsp_op_q    <= head_op;
            end
          end
        end
        SEND1: begin
          state_q    <= SEND2;
          req_cmd_q  <= 4'd0;
          req_data_q <= op2_q;
        end
        SEND2: begin
          state_q    <= WAIT;
          req_data_q <= '0;
          cnt_q      <= '0;
        end
        WAIT: begin
          if (out_resp != 2'd0) begin
            state_q     <= HOLD;
            rsp_valid_q <= 1'b1;
            rsp_code_q  <= out_resp;
            rsp_data_q  <= out_data;
            rsp_op_q    <= op_q;
          end else if (cnt_q == TW'(TIMEOUT - 1)) begin
            state_q     <= HOLD;
            rsp_valid_q <= 1'b1;
            rsp_code_q  <= 2'd3;
            rsp_data_q  <= '0;
            rsp_op_q    <= op_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign req_cmd_in  = req_cmd_q;
  assign req_data_in = req_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_code    = rsp_code_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_op      = rsp_op_q;
  assign busy        = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_calc_port_sequencer.sv
// Bench for calc_port_sequencer: a port responder model, an in-order operation/result
// scoreboard checked every cycle, and directed scenarios with hand-computed timing.
module tb_calc_port_sequencer;

  localparam int DEPTH   = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [DATA_W-1:0] cmd_op1, cmd_op2;
  logic [3:0]        req_cmd_in;
  logic [DATA_W-1:0] req_data_in;
  logic [1:0]        out_resp;
  logic [DATA_W-1:0] out_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_code;
  logic [DATA_W-1:0] rsp_data;
  logic [3:0]        rsp_op;
  logic              busy;

  calc_port_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
    .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .out_resp(out_resp), .out_data(out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  int n_cmp = 0;
  int n_err = 0;
  int n_rsp = 0;
  int cyc = 0;
  int resp_delay = 2;     // port answers this many cycles after SEND2; 0 = never
  int inject_until = 0;   // spurious out_resp=1 driven while cyc < inject_until

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic is_legal(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd2) || (op == 4'd5) || (op == 4'd6);
  endfunction

  // Calculator port behaviour: returns {code, data}.
  function automatic logic [33:0] port_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (op)
      4'd1:    return {(s[32] ? 2'd2 : 2'd1), s[31:0]};
      4'd2:    return {((a < b) ? 2'd2 : 2'd1), a - b};
      4'd5:    return (b < 32) ? {2'd1, a << b} : {2'd2, 32'd0};
      4'd6:    return (b < 32) ? {2'd1, a >> b} : {2'd2, 32'd0};
      default: return {2'd3, 32'd0};
    endcase
  endfunction

  // ---------------- port responder ----------------
  logic        r_saw1;
  logic [3:0]  r_op;
  logic [31:0] r_a, r_b;
  int          r_timer;

  initial begin
    out_resp = 2'd0;
    out_data = '0;
    r_saw1   = 1'b0;
    r_timer  = 0;
    forever begin
      @(negedge clk);
      out_resp = 2'd0;
      out_data = '0;
      if (reset) begin
        r_saw1  = 1'b0;
        r_timer = 0;
      end else begin
        if (cyc < inject_until) begin
          out_resp = 2'd1;
          out_data = 32'h55;
        end
        if (r_timer > 0) begin
          r_timer--;
          if (r_timer == 0) {out_resp, out_data} = port_result(r_op, r_a, r_b);
        end
        if (r_saw1) begin
          r_b    = req_data_in;
          r_saw1 = 1'b0;
          if (resp_delay > 0) r_timer = resp_delay;
        end else if (req_cmd_in != 4'd0) begin
          r_op   = req_cmd_in;
          r_a    = req_data_in;
          r_saw1 = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard / compare process ----------------
  op_t         op_q[$];
  op_t         infl;
  op_t         head;
  logic        infl_valid = 1'b0;
  logic        exp_send2  = 1'b0;
  logic [33:0] infl_exp;
  logic        hold_prev  = 1'b0;
  logic [37:0] prev_rsp;
  logic [37:0] exp_rsp;
  logic        have_exp;

  always @(negedge clk) begin
    if (reset) begin
      check("reset_ctrl", {cmd_ready, busy, rsp_valid}, 3'b100);
      check("reset_req", {req_cmd_in, req_data_in}, 36'd0);
      check("reset_rsp", {rsp_code, rsp_data, rsp_op}, 38'd0);
      op_q.delete();
      infl_valid = 1'b0;
      exp_send2  = 1'b0;
      hold_prev  = 1'b0;
    end else begin
      // port side: every issue must be the next queued legal op, one at a time
      if (exp_send2) begin
        check("send2_cmd", req_cmd_in, 4'd0);
        check("send2_data", req_data_in, infl.b);
        exp_send2 = 1'b0;
      end else if (req_cmd_in != 4'd0) begin
        check("issue_while_in_flight", infl_valid, 1'b0);
        check("issue_op_legal", is_legal(req_cmd_in), 1'b1);
        if (op_q.size() == 0) begin
          check("unexpected_issue", req_cmd_in, 4'd0);
        end else begin
          infl = op_q.pop_front();
          check("issue_cmd", req_cmd_in, infl.op);
          check("issue_data", req_data_in, infl.a);
          infl_exp   = (resp_delay >= 1 && resp_delay <= TIMEOUT) ?
                       port_result(infl.op, infl.a, infl.b) : {2'd3, 32'd0};
          infl_valid = 1'b1;
          exp_send2  = 1'b1;
        end
      end else begin
        check("idle_data", req_data_in, 32'd0);
      end

      // response side
      if (rsp_valid) begin
        if (hold_prev) check("hold_stable", {rsp_code, rsp_data, rsp_op}, prev_rsp);
        if (rsp_ready) begin
          have_exp = 1'b1;
          if (infl_valid && !exp_send2) begin
            exp_rsp    = {infl_exp, infl.op};
            infl_valid = 1'b0;
          end else if (!infl_valid && op_q.size() != 0 && !is_legal(op_q[0].op)) begin
            head    = op_q.pop_front();
            exp_rsp = {2'd2, 32'd0, head.op};
          end else begin
            have_exp = 1'b0;
            check("unexpected_rsp", rsp_valid, 1'b0);
          end
          if (have_exp) begin
            check("rsp", {rsp_code, rsp_data, rsp_op}, exp_rsp);
            n_rsp++;
          end
        end
        hold_prev = !rsp_ready;
        prev_rsp  = {rsp_code, rsp_data, rsp_op};
      end else begin
        hold_prev = 1'b0;
      end

      // upstream side: accepted at the coming edge
      if (cmd_valid && cmd_ready) op_q.push_back('{cmd_op, cmd_op1, cmd_op2});
    end
  end

  // ---------------- stimulus helpers (called at posedge + 1) ----------------
  task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_op1   = a;
    cmd_op2   = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        return;
      end
    end
    fail_bound("push_accept");
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rsp_valid) return;
    end
    fail_bound("wait_rsp_valid");
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid && op_q.size() == 0 && !infl_valid) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    fail_bound("wait_idle");
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    cmd_op1   = '0;
    cmd_op2   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {cmd_ready, busy, rsp_valid}, 3'b100);
    @(posedge clk);
    #1;

    // Basic add, port answers 2 cycles after SEND2: push t, SEND1 t+2, SEND2 t+3, valid t+6
    resp_delay = 2;
    push(4'd1, 32'd5, 32'd3);
    @(negedge clk); check("t1_idle_cycle", {req_cmd_in, busy}, {4'd0, 1'b1});
    @(negedge clk); check("t1_send1", {req_cmd_in, req_data_in}, {4'd1, 32'd5});
    @(negedge clk); check("t1_send2", {req_cmd_in, req_data_in}, {4'd0, 32'd3});
    @(negedge clk);
    @(negedge clk); check("t1_waiting", rsp_valid, 1'b0);
    @(negedge clk); check("t1_rsp", {rsp_valid, rsp_code, rsp_data, rsp_op}, {1'b1, 2'd1, 32'd8, 4'd1});
    @(negedge clk); check("t1_rsp_taken", rsp_valid, 1'b0);
    wait_idle(50);

    // Unsupported opcode 3: rejected locally one cycle after the pop
    push(4'd3, 32'h7, 32'h9);
    @(negedge clk); check("t2_pop_cycle", rsp_valid, 1'b0);
    @(negedge clk); check("t2_reject", {rsp_valid, rsp_code, rsp_data, rsp_op}, {1'b1, 2'd2, 32'd0, 4'd3});
    wait_idle(50);

    // Answer on the very last WAIT cycle still counts
    resp_delay = TIMEOUT;
    push(4'd1, 32'h10, 32'h20);
    repeat (258) @(negedge clk);
    check("t3_before_last", rsp_valid, 1'b0);
    @(negedge clk);
    check("t3_last_cycle_rsp", {rsp_valid, rsp_code, rsp_data, rsp_op}, {1'b1, 2'd1, 32'h30, 4'd1});
    wait_idle(20);

    // Port silent: timeout after 255 WAIT cycles, then a late answer is ignored
    resp_delay = 0;
    push(4'd1, 32'd2, 32'd2);
    repeat (258) @(negedge clk);
    check("t4_before_timeout", rsp_valid, 1'b0);
    @(negedge clk);
    check("t4_timeout", {rsp_valid, rsp_code, rsp_data, rsp_op}, {1'b1, 2'd3, 32'd0, 4'd1});
    inject_until = cyc + 4;
    resp_delay   = 3;
    @(posedge clk);
    #1;
    push(4'd6, 32'h100, 32'd4);
    wait_idle(50);
    check("t4_rsp_count", n_rsp, 5);

    // Downstream stalled 10 cycles in HOLD while the FIFO fills
    rsp_ready  = 1'b0;
    resp_delay = 1;
    push(4'd2, 32'd10, 32'd4);
    wait_valid(20);
    @(posedge clk);
    #1;
    push(4'd1, 32'd1, 32'd1);
    push(4'd5, 32'd1, 32'd4);
    push(4'd6, 32'h80, 32'd3);
    push(4'd2, 32'd3, 32'd5);
    @(negedge clk);
    check("t5_full", {cmd_ready, busy}, 2'b01);
    @(posedge clk);
    #1;
    fork
      push(4'd1, 32'hFFFF_FFFF, 32'd1);
      begin
        repeat (4) begin
          @(negedge clk);
          check("t5_full_stall", {cmd_ready, rsp_valid}, 2'b01);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk); check("t5_ready_cycle", {rsp_valid, cmd_ready}, 2'b10);
        @(negedge clk); check("t5_after_hs", {rsp_valid, cmd_ready}, 2'b00);
        @(negedge clk); check("t5_slot_free", cmd_ready, 1'b1);
      end
    join
    wait_idle(150);
    check("t5_rsp_count", n_rsp, 11);

    // Reset while WAITing with two entries queued
    resp_delay = 0;
    push(4'd1, 32'd1, 32'd1);
    push(4'd2, 32'd2, 32'd2);
    push(4'd5, 32'd1, 32'd1);
    repeat (6) @(negedge clk);
    check("t6_in_wait", {busy, rsp_valid}, 2'b10);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_reset_ctrl", {cmd_ready, busy, rsp_valid}, 3'b100);
    check("t6_reset_req", {req_cmd_in, req_data_in}, 36'd0);
    check("t6_reset_rsp", {rsp_code, rsp_data, rsp_op}, 38'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("t6_quiet", {rsp_valid, busy, req_cmd_in}, 6'd0);
    check("t6_rsp_count", n_rsp, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
